fftshift_demap256: RTL
======================

# fftshift_demap256

Downstream neighbour of the 256-point bit-reversal reorder stage in the PUSCH receive FFT chain. Consumes one natural-order 256-bin FFT burst and re-emits it in centred (fftshift) order: bins 128..255 first, then bins 0..127. Only the allocated subcarrier window [start_sc, start_sc+num_sc-1] of the shifted index is forwarded to the RE demapping logic. Half-symbol buffering makes the output stream contiguous with a fixed latency.

## Interface
- WIDTH, 18, signed sample width of each I/Q component
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- di_re, di_im  in  WIDTH  signed input bin, natural order (bin 0 first)
- di_en  in  1  input bin valid; one bin per asserted cycle
- start_sc  in  8  first allocated shifted index; sampled with bin 0
- num_sc  in  9  allocated count, 0..256; sampled with bin 0
- do_re, do_im  out  WIDTH  signed output sample; 0 when do_en=0
- do_en  out  1  output sample valid (allocated only)
- do_idx  out  8  shifted index k of current output; 0 when do_en=0
- do_last  out  1  high with the last allocated sample of the symbol
- sym_done  out  1  one-cycle pulse at end of symbol (shifted slot 255)
- overflow  out  1  sticky error flag; cleared only by rst

## Operation
- Shifted index k = bin XOR 128 (bins 128..255 become k=0..127; bins 0..127 become k=128..255).
- Internal 128-entry x 2*WIDTH RAM, synchronous read, holds bins 0..127.
- Input counter in_cnt (8 bits) advances only on di_en. State does not change on di_en=0 cycles within a fill.
- States:
  - IDLE: wait for di_en. On the first di_en, latch start_sc/num_sc, write bin 0, go to FILL.
  - FILL: bins 1..127 written to RAM at addr in_cnt[6:0]. After bin 127, go to PASS.
  - PASS: bins 128..255 are registered straight through. Output k=in_cnt-128 appears 1 cycle after the sample. After bin 255, go to DRAIN.
  - DRAIN: 128 consecutive cycles with drain_cnt 0..127 as read address. Output k=128+drain_cnt appears 1 cycle after the address. After drain_cnt=127, go to IDLE.
- Window: end = min(start_sc + num_sc, 256), computed in 10 bits with no wrap. A slot k is emitted (do_en=1) iff start_sc <= k < end.
  - num_sc=0 emits nothing.
  - num_sc > 256 is treated as 256.
- do_last = 1 on the emitted slot with k = end-1. Never asserted when nothing is emitted.
- sym_done pulses in the output cycle of slot k=255, whether or not that slot is emitted.
- di_en asserted in DRAIN: sample dropped, overflow set to 1, and the drain completes normally.
- di_en during PASS/FILL is normal input; no overflow.
- Config inputs are ignored except with bin 0.

## Timing
- Reset (async assert): state=IDLE, counters=0, and every output is 0. Any partial burst is discarded.
- With contiguous di_en, bin 0 arrives at cycle 0:
  - slot k<128 comes out at cycle 129+k.
  - slot k>=128 comes out at cycle 129+k as well, with no gap between k=127 (cycle 256) and k=128 (cycle 257).
- Full allocation gives do_en high for cycles 129..384 continuously. sym_done is at cycle 384.
- With gaps in di_en:
  - PASS outputs follow their input by exactly 1 cycle.
  - DRAIN starts the cycle after bin 255 is accepted.
- Back-to-back symbols: next bin 0 is accepted no earlier than the cycle after drain_cnt=127 (cycle 384 in contiguous case). The upstream reorder stage's ≥256-cycle output gap satisfies this.
- No backpressure. The consumer must accept do_en every cycle.

## Test plan
- Full allocation: bin n = (re=n, im=-n), start_sc=0, num_sc=256, contiguous.
  - Expect do_en on cycles 129..384, with do_idx 0..255.
  - do_re sequence 128..255, then 0..127.
  - do_last and sym_done both at cycle 384.
- Partial window: start_sc=100, num_sc=50.
  - Expect 50 samples, k=100..149, at cycles 229..278, do_re = k XOR 128.
  - do_last at k=149; sym_done at cycle 384.
- Clipping and empty:
  - start_sc=200, num_sc=100: emits k=200..255 (56 samples), do_last at k=255.
  - Next symbol num_sc=0: zero do_en, sym_done still pulses.
- Gapped input: di_en toggles 1,0 every cycle for 256 bins.
  - Output values and order match the full-allocation case.
  - PASS outputs one cycle after each accepted bin; DRAIN 128 contiguous cycles.
- Overflow: assert di_en at drain_cnt=10.
  - overflow goes to 1 and stays 1.
  - Current symbol's remaining output is unchanged.
  - Cleared only by rst.
- Async reset mid-PASS (after bin 150), asserted between clock edges:
  - Outputs go to 0 immediately.
  - A fresh full symbol afterwards reproduces scenario 1 exactly.

Source files
------------

// File: rtl/fftshift_demap256.sv
// Natural-order 256-bin FFT burst to fftshift (centred) order. Only the
// allocated subcarrier window of the shifted index is forwarded.
module fftshift_demap256 #(
  parameter int WIDTH = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] di_re,
  input  logic signed [WIDTH-1:0] di_im,
  input  logic                    di_en,
  input  logic [7:0]              start_sc,
  input  logic [8:0]              num_sc,
  output logic signed [WIDTH-1:0] do_re,
  output logic signed [WIDTH-1:0] do_im,
  output logic                    do_en,
  output logic [7:0]              do_idx,
  output logic                    do_last,
  output logic                    sym_done,
  output logic                    overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_PASS  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]  state;
  logic [7:0]  in_cnt;
  logic [6:0]  drain_cnt;
  logic [7:0]  win_start;
  logic [9:0]  win_end;

  logic [2*WIDTH-1:0] ram [128];
  logic               ram_we;
  logic [6:0]         ram_waddr;

  logic               slot_vld_p0;
  logic [7:0]         slot_k_p0;
  logic               slot_ram_p0;

  logic [2*WIDTH-1:0] pass_q_p1;
  logic [2*WIDTH-1:0] ram_q_p1;
  logic [2*WIDTH-1:0] sample_p1;
  logic               vld_p1;
  logic [7:0]         idx_p1;
  logic               sel_ram_p1;
  logic               last_p1;
  logic               done_p1;

  // Window end is computed wide so start+num never wraps past 255.
  function automatic logic [9:0] window_end(input logic [7:0] st, input logic [8:0] n);
    logic [9:0] n_clip;
    logic [9:0] e;
    n_clip = (n > 9'd256) ? 10'd256 : {1'b0, n};
    e      = {2'b00, st} + n_clip;
    return (e > 10'd256) ? 10'd256 : e;
  endfunction

  function automatic logic in_window(input logic [7:0] k, input logic [7:0] st,
                                     input logic [9:0] e);
    return (k >= st) && ({2'b00, k} < e);
  endfunction

  function automatic logic is_last(input logic [7:0] k, input logic [7:0] st,
                                   input logic [9:0] e);
    return in_window(k, st, e) && ({2'b00, k} == (e - 10'd1));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_cnt    <= '0;
      drain_cnt <= '0;
      win_start <= '0;
      win_end   <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (di_en) begin
            win_start <= start_sc;
            win_end   <= window_end(start_sc, num_sc);
            in_cnt    <= 8'd1;
            state     <= S_FILL;
          end
        end
        S_FILL: begin
          if (di_en) begin
            in_cnt <= in_cnt + 8'd1;
            if (in_cnt == 8'd127) state <= S_PASS;
          end
        end
        S_PASS: begin
          if (di_en) begin
            in_cnt <= in_cnt + 8'd1;
            if (in_cnt == 8'd255) begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + 7'd1;
          // No backpressure exists, so a bin arriving now is lost.
          if (di_en) overflow <= 1'b1;
          if (drain_cnt == 7'd127) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p0: lower half goes to RAM, upper half selects the output slot.
  always_comb begin
    ram_we    = di_en && ((state == S_IDLE) || (state == S_FILL));
    ram_waddr = (state == S_IDLE) ? 7'd0 : in_cnt[6:0];
  end

  always_comb begin
    slot_vld_p0 = 1'b0;
    slot_k_p0   = '0;
    slot_ram_p0 = 1'b0;
    if ((state == S_PASS) && di_en) begin
      slot_vld_p0 = 1'b1;
      slot_k_p0   = {1'b0, in_cnt[6:0]};
    end else if (state == S_DRAIN) begin
      slot_vld_p0 = 1'b1;
      slot_k_p0   = {1'b1, drain_cnt};
      slot_ram_p0 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= {di_re, di_im};
    ram_q_p1 <= ram[drain_cnt];
    if ((state == S_PASS) && di_en) pass_q_p1 <= {di_re, di_im};
  end

  // Stage p1: registered slot control, one cycle behind its source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      idx_p1     <= '0;
      sel_ram_p1 <= 1'b0;
      last_p1    <= 1'b0;
      done_p1    <= 1'b0;
    end else begin
      vld_p1     <= slot_vld_p0 && in_window(slot_k_p0, win_start, win_end);
      idx_p1     <= slot_k_p0;
      sel_ram_p1 <= slot_ram_p0;
      last_p1    <= slot_vld_p0 && is_last(slot_k_p0, win_start, win_end);
      done_p1    <= slot_vld_p0 && (slot_k_p0 == 8'd255);
    end
  end

  always_comb begin
    sample_p1 = sel_ram_p1 ? ram_q_p1 : pass_q_p1;
    do_en     = vld_p1;
    do_re     = vld_p1 ? $signed(sample_p1[2*WIDTH-1:WIDTH]) : '0;
    do_im     = vld_p1 ? $signed(sample_p1[WIDTH-1:0]) : '0;
    do_idx    = vld_p1 ? idx_p1 : 8'd0;
    do_last   = vld_p1 && last_p1;
    sym_done  = done_p1;
  end

endmodule
